// File: rtl/ps2_host_tx_if.sv
// Command-side handshake and status bundle for the PS/2 host transmitter.
// master = command logic, slave = ps2_host_tx.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_err, timeout_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, ack_err, timeout_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift on device clocks, check ACK.
// Define PS2_TX_RETRY_EN for one automatic resend after a NACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          resetn,
    ps2_host_tx_if.slave  cmd,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
    localparam logic [ToW-1:0]  ToTerm  = ToW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StSend,
        StAck,
        StWaitIdle,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [9:0]      shift_q, shift_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic            data_oe_q, data_oe_d;
    logic            ack_err_q, ack_err_d;
    logic            to_err_q, to_err_d;
`ifdef PS2_TX_RETRY_EN
    logic [7:0]      byte_q, byte_d;
    logic            retry_q, retry_d;
`endif

    // Synchronizers reset high so the idle bus never looks like a falling edge.
    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;
    logic fall;
    logic to_hit;
    logic tx_ready, busy, done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    assign fall   = clk_prev_q & ~clk_sync_q;
    // A fall in the same cycle as the terminal count takes priority.
    assign to_hit = (to_cnt_q == ToTerm) & ~fall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            data_oe_q <= 1'b0;
            ack_err_q <= 1'b0;
            to_err_q  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            byte_q    <= '0;
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            data_oe_q <= data_oe_d;
            ack_err_q <= ack_err_d;
            to_err_q  <= to_err_d;
`ifdef PS2_TX_RETRY_EN
            byte_q    <= byte_d;
            retry_q   <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        inh_cnt_d   = inh_cnt_q;
        to_cnt_d    = to_cnt_q;
        data_oe_d   = data_oe_q;
        ack_err_d   = ack_err_q;
        to_err_d    = to_err_q;
`ifdef PS2_TX_RETRY_EN
        byte_d      = byte_q;
        retry_d     = retry_q;
`endif
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        done        = 1'b0;

        // Edge-to-edge timer shared by every device-clocked state.
        if (state_q inside {StSend, StAck, StWaitIdle}) begin
            if (fall) begin
                to_cnt_d = '0;
            end else if (!to_hit) begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (cmd.tx_valid) begin
                    shift_d   = {1'b1, ~^cmd.tx_data, cmd.tx_data};
                    bit_cnt_d = '0;
                    inh_cnt_d = '0;
                    data_oe_d = 1'b0;
                    ack_err_d = 1'b0;
                    to_err_d  = 1'b0;
`ifdef PS2_TX_RETRY_EN
                    byte_d    = cmd.tx_data;
                    retry_d   = 1'b0;
`endif
                    state_d   = StInhibit;
                end
            end

            StInhibit: begin
                ps2_clk_oe = 1'b1;
                if (inh_cnt_q == InhLast) begin
                    ps2_data_oe = 1'b1;
                    state_d     = StReq;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end

            StReq: begin
                // Start bit stays driven until the first device fall.
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                data_oe_d   = 1'b1;
                to_cnt_d    = '0;
                state_d     = StSend;
            end

            StSend: begin
                ps2_data_oe = data_oe_q;
                if (fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[9:1]};
                    if (bit_cnt_q == 4'd9) begin
                        state_d = StAck;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (to_hit) begin
                    data_oe_d = 1'b0;
                    to_err_d  = 1'b1;
                    state_d   = StDone;
                end
            end

            StAck: begin
                if (fall) begin
                    if (data_sync_q) begin
`ifdef PS2_TX_RETRY_EN
                        if (!retry_q) begin
                            retry_d   = 1'b1;
                            shift_d   = {1'b1, ~^byte_q, byte_q};
                            bit_cnt_d = '0;
                            inh_cnt_d = '0;
                            data_oe_d = 1'b0;
                            state_d   = StInhibit;
                        end else begin
                            ack_err_d = 1'b1;
                            state_d   = StWaitIdle;
                        end
`else
                        ack_err_d = 1'b1;
                        state_d   = StWaitIdle;
`endif
                    end else begin
                        state_d = StWaitIdle;
                    end
                end else if (to_hit) begin
                    to_err_d = 1'b1;
                    state_d  = StDone;
                end
            end

            StWaitIdle: begin
                if (clk_sync_q && data_sync_q) begin
                    state_d = StDone;
                end else if (to_hit) begin
                    to_err_d = 1'b1;
                    state_d  = StDone;
                end
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign tx_ready = (state_q == StIdle);
    assign busy     = ~tx_ready;

    assign cmd.tx_ready    = tx_ready;
    assign cmd.busy        = busy;
    assign cmd.done        = done;
    assign cmd.ack_err     = ack_err_q;
    assign cmd.timeout_err = to_err_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter; the send-direction counterpart of the existing ps2_keyboard receiver, sharing the same ps2_clk/ps2_data pins through open-drain enables. It sends one command byte to the keyboard, for example LED set (0xED) or reset (0xFF). The sequence is: inhibit the line, issue the request-to-send, shift the frame out on device-generated clocks, then check the device ACK. It reports completion and error status to the command logic next to ps2_keyboard in top.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before start (100 us at 50 MHz)
TIMEOUT_CYCLES, 1000000, max clk cycles allowed between consecutive device clock falling edges (20 ms at 50 MHz)

Ports:
clk  input  1  system clock, sole clock domain
resetn  input  1  asynchronous active-low reset
tx_data  input  8  command byte
tx_valid  input  1  request to send tx_data
tx_ready  output  1  high only in IDLE; a transfer is accepted on tx_valid & tx_ready
ps2_clk_in  input  1  raw ps2_clk pin level (asynchronous)
ps2_data_in  input  1  raw ps2_data pin level (asynchronous)
ps2_clk_oe  output  1  1 = drive ps2_clk low; 0 = release
ps2_data_oe  output  1  1 = drive ps2_data low; 0 = release
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at the end of every transaction
ack_err  output  1  device did not ACK; valid on done, held until next accept
timeout_err  output  1  clock-edge timeout; valid on done, held until next accept

Behaviour:
- Reset (async, resetn=0): state IDLE, tx_ready=1, busy=0, ps2_clk_oe=0, ps2_data_oe=0, done=0, ack_err=0, timeout_err=0. The lines are released immediately, including mid-frame.
- Input sync: 2-FF synchronizers on both pins.
  - fall = prev_sync_clk & ~sync_clk.
  - A pin falling edge is therefore seen 3 clk cycles later.
- Accept: on tx_valid & tx_ready, capture the 10-bit shift register {1'b1 stop, ~^tx_data odd parity, tx_data}. Clear ack_err and timeout_err, then go to INHIBIT. tx_valid is ignored while not ready.
- INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles; data_oe=1 on the last cycle.
- REQ: one cycle with clk_oe=1 and data_oe=1 (start bit). Then clk_oe=0, clear the timeout counter, go to SEND.
- SEND: on each fall, data_oe <= ~shift[0], shift right, bit count +1.
  - Order: D0..D7, parity, stop.
  - After the 10th fall (stop placed, data_oe=0), go to ACK.
- ACK: on the next fall, sample sync_data. 1 sets ack_err=1. Go to WAIT_IDLE.
- WAIT_IDLE: when sync_clk=1 and sync_data=1 together, pulse done for 1 cycle and return to IDLE.
- Timeout: applies in SEND, ACK and WAIT_IDLE.
  - The counter clears on each fall.
  - When it reaches TIMEOUT_CYCLES: release both lines, set timeout_err=1, pulse done, go to IDLE. ack_err is left unchanged.
- Edge cases:
  - A fall in INHIBIT or REQ is ignored.
  - If a fall and the timeout terminal count occur in the same cycle, the fall wins.
  - done and tx_ready are never both 1 in the same cycle; tx_ready rises the cycle after done.
- Counter widths come from $clog2 of the parameters; no wrap-around is allowed before the terminal count.

Optional Feature:
PS2_TX_RETRY_EN:
- Defined: on NACK in ACK, one automatic resend of the same byte, re-entering INHIBIT with the shift register reloaded. done is not pulsed between attempts. ack_err is set only if the retry also NACKs. A timeout never retries.
- Undefined: a NACK ends the transaction immediately with ack_err=1.

Test Plan:
- Send 0xED with a device model clocking at 12 kHz that ACKs → lines observed: clk low ≥5000 cycles, start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Then exactly one done pulse with ack_err=0 and timeout_err=0.
- Send 0x00 → parity bit 1. Send 0x01 → parity bit 0. Both complete with ack_err=0.
- Device leaves data high on the ACK clock → done pulse with ack_err=1.
  - With PS2_TX_RETRY_EN: a second full frame of the same byte appears, and ack_err=1 only after the second NACK.
- Device stops clocking after bit 3 → after 1000000 cycles: timeout_err=1, done pulse, both oe=0, tx_ready=1 on the next cycle.
- Assert resetn=0 mid-SEND → ps2_clk_oe=0 and ps2_data_oe=0 in the same cycle, busy=0. A new 0xFF send after release completes normally.
- Hold tx_valid=1 with changing tx_data while busy → only the byte captured at accept is transmitted, and a second transfer starts only after done.
